// File: rtl/tdc_pulse_gen_pkg.sv
// Shared types and constants for the TDC/trigger pulse generator.
// The state enum, default widths and the LFSR seed/tap constants live here.
package tdc_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CNT_BITS_DEF   = 16;
  localparam int WIDTH_BITS_DEF = 12;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/tdc_pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter the TDC pulse width once per period.
// Only compiled when TDC_PULSE_GEN_RANDOM_EN is defined.
`ifdef TDC_PULSE_GEN_RANDOM_EN
module tdc_pulse_gen_lfsr
  import tdc_pulse_gen_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  output logic [7:0] RND
);

  logic [15:0] q;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)  q <= LFSR_SEED;
    else if (EN) q <= {q[14:0], ^(q & LFSR_TAPS)};

  assign RND = q[7:0];

endmodule
`endif

// File: rtl/tdc_pulse_gen.sv
// Programmable trigger + TDC pulse source for receiver self-test/calibration.
// Define TDC_PULSE_GEN_RANDOM_EN to add per-period LFSR width jitter (WIDTH_MASK port).
module tdc_pulse_gen
  import tdc_pulse_gen_pkg::*;
#(
  parameter int CNT_BITS   = CNT_BITS_DEF,
  parameter int WIDTH_BITS = WIDTH_BITS_DEF,
  parameter int TRIG_LEN   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [WIDTH_BITS-1:0] WIDTH,
  input  logic [7:0]            DELAY,
  input  logic [CNT_BITS-1:0]   PERIOD,
  input  logic [CNT_BITS-1:0]   REPEAT,
  input  logic                  EN_TRIG,
  input  logic                  INVERT_TDC,
  input  logic                  INVERT_TRIG,
`ifdef TDC_PULSE_GEN_RANDOM_EN
  input  logic [7:0]            WIDTH_MASK,
`endif
  output logic                  TDC_OUT,
  output logic                  TRIG_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_BITS-1:0]   EVENT_CNT
);

  // Wide enough for DELAY+WIDTH(+jitter)+1 and PERIOD without wrapping
  localparam int WB1 = WIDTH_BITS + 1;
  localparam int M1  = (CNT_BITS > WB1) ? CNT_BITS : WB1;
  localparam int M2  = (M1 > 9) ? M1 : 9;
  localparam int SW  = M2 + 2;

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   t;
  logic [CNT_BITS-1:0]   period_sh, repeat_sh;
  logic [WIDTH_BITS-1:0] width_sh;
  logic [7:0]            delay_sh;
  logic                  en_trig_sh;
  logic                  stop_pend;
  logic                  tdc_q, trig_q;

  logic [SW-1:0]         width_eff, tdc_end, p_wide;
  logic [CNT_BITS-1:0]   p_eff, evt_nxt;
  logic                  running, wrap, last, tdc_raw, trig_raw;

`ifdef TDC_PULSE_GEN_RANDOM_EN
  logic [7:0] mask_sh;
  logic [7:0] rnd;

  tdc_pulse_gen_lfsr u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (wrap),
    .RND   (rnd)
  );

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)                    mask_sh <= '0;
    else if (state == IDLE && START) mask_sh <= WIDTH_MASK;

  assign width_eff = SW'(width_sh) + SW'(rnd & mask_sh);
`else
  assign width_eff = SW'(width_sh);
`endif

  assign running = (state == RUN);
  assign tdc_end = SW'(delay_sh) + width_eff;

  // Stretch the period so both outputs get at least one idle cycle
  always_comb begin
    p_wide = SW'(period_sh);
    if (tdc_end + SW'(1) > p_wide) p_wide = tdc_end + SW'(1);
    if (SW'(TRIG_LEN + 1) > p_wide) p_wide = SW'(TRIG_LEN + 1);
    p_eff = (|p_wide[SW-1:CNT_BITS]) ? '1 : p_wide[CNT_BITS-1:0];
  end

  assign wrap     = running && (t == p_eff - 1'b1);
  assign evt_nxt  = (&EVENT_CNT) ? EVENT_CNT : EVENT_CNT + 1'b1;
  assign last     = wrap && (stop_pend || STOP ||
                             (repeat_sh != '0 && evt_nxt == repeat_sh));
  assign tdc_raw  = running && (SW'(t) >= SW'(delay_sh)) && (SW'(t) < tdc_end);
  assign trig_raw = running && en_trig_sh && (SW'(t) < SW'(TRIG_LEN));

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      t          <= '0;
      period_sh  <= '0;
      repeat_sh  <= '0;
      width_sh   <= '0;
      delay_sh   <= '0;
      en_trig_sh <= 1'b0;
      stop_pend  <= 1'b0;
      EVENT_CNT  <= '0;
      tdc_q      <= 1'b0;
      trig_q     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      tdc_q  <= tdc_raw;
      trig_q <= trig_raw;
      BUSY   <= running;
      DONE   <= (state == FINISH);
      if (state == IDLE && START) begin
        period_sh  <= PERIOD;
        repeat_sh  <= REPEAT;
        width_sh   <= WIDTH;
        delay_sh   <= DELAY;
        en_trig_sh <= EN_TRIG;
        stop_pend  <= STOP;
        t          <= '0;
        EVENT_CNT  <= '0;
      end else if (running) begin
        if (STOP) stop_pend <= 1'b1;
        if (wrap) begin
          t         <= '0;
          EVENT_CNT <= evt_nxt;
        end else begin
          t <= t + 1'b1;
        end
      end
    end

  // Polarity follows the live invert inputs so idle level tracks them in reset too
  assign TDC_OUT  = tdc_q ^ INVERT_TDC;
  assign TRIG_OUT = trig_q ^ INVERT_TRIG;

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Scoreboard bench for tdc_pulse_gen: a period-level model queues expected per-cycle
// output records; a negedge monitor pops and compares whenever BUSY or DONE is seen.
module tb_tdc_pulse_gen;
  import tdc_pulse_gen_pkg::*;

  localparam int CB = 16;
  localparam int WB = 12;
  localparam int TL = 4;

  logic          CLK = 1'b0, RST_N = 1'b0, START = 1'b0, STOP = 1'b0;
  logic          EN_TRIG = 1'b0, INVERT_TDC = 1'b0, INVERT_TRIG = 1'b0;
  logic [WB-1:0] WIDTH = '0;
  logic [7:0]    DELAY = '0;
  logic [CB-1:0] PERIOD = '0, REPEAT = '0;
  logic          TDC_OUT, TRIG_OUT, BUSY, DONE;
  logic [CB-1:0] EVENT_CNT;
`ifdef TDC_PULSE_GEN_RANDOM_EN
  logic [7:0]    WIDTH_MASK = '0;
  logic [15:0]   lfsr_m = 16'hACE1;
`endif

  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic          tdc;
    logic          trig;
    logic          busy;
    logic          done;
    logic [CB-1:0] evt;
  } rec_t;

  rec_t          exp_q[$];
  logic [CB-1:0] idle_evt = '0;

  always #5 CLK = ~CLK;

  tdc_pulse_gen #(.CNT_BITS(CB), .WIDTH_BITS(WB), .TRIG_LEN(TL)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .STOP        (STOP),
    .WIDTH       (WIDTH),
    .DELAY       (DELAY),
    .PERIOD      (PERIOD),
    .REPEAT      (REPEAT),
    .EN_TRIG     (EN_TRIG),
    .INVERT_TDC  (INVERT_TDC),
    .INVERT_TRIG (INVERT_TRIG),
`ifdef TDC_PULSE_GEN_RANDOM_EN
    .WIDTH_MASK  (WIDTH_MASK),
`endif
    .TDC_OUT     (TDC_OUT),
    .TRIG_OUT    (TRIG_OUT),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .EVENT_CNT   (EVENT_CNT)
  );

  // Monitor: outputs are compared in active-high form (invert removed)
  always @(negedge CLK) begin
    rec_t act, e;
    act = '{tdc: TDC_OUT ^ INVERT_TDC, trig: TRIG_OUT ^ INVERT_TRIG,
            busy: BUSY, done: DONE, evt: EVENT_CNT};
    if (!RST_N) begin
      idle_evt = '0;
    end else if (BUSY || DONE) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: busy=%0b done=%0b evt=%0d, expected idle",
                 BUSY, DONE, EVENT_CNT);
      end else begin
        e = exp_q.pop_front();
        if (e.done) idle_evt = e.evt;
        if (act !== e) begin
          n_fail++;
          $display("FAIL burst_cycle: got tdc=%0b trig=%0b busy=%0b done=%0b evt=%0d, expected tdc=%0b trig=%0b busy=%0b done=%0b evt=%0d",
                   act.tdc, act.trig, act.busy, act.done, act.evt,
                   e.tdc, e.trig, e.busy, e.done, e.evt);
        end
      end
    end else if (exp_q.size() == 0) begin
      n_chk++;
      if (act.tdc !== 1'b0 || act.trig !== 1'b0 || act.evt !== idle_evt) begin
        n_fail++;
        $display("FAIL idle_state: got tdc=%0b trig=%0b evt=%0d, expected tdc=0 trig=0 evt=%0d",
                 act.tdc, act.trig, act.evt, idle_evt);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int peff(input int p, input int d, input int w);
    int r = p;
    if (d + w + 1 > r) r = d + w + 1;
    if (TL + 1 > r)    r = TL + 1;
    if (r > 65535)     r = 65535;
    return r;
  endfunction

  // Reference model: expands a burst into one record per output cycle, then DONE.
  // stop_g is the burst-relative cycle index during which STOP was seen (-1 = none).
  task automatic push_burst(input int w, input int d, input int p, input int rep,
                            input bit en, input int stop_g, output int len);
    int   cnt = 0, g = 0, pe, wi;
    bit   last_p;
    rec_t r;
    forever begin
      wi = w;
`ifdef TDC_PULSE_GEN_RANDOM_EN
      wi = w + int'(lfsr_m[7:0] & WIDTH_MASK);
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
      pe     = peff(p, d, wi);
      last_p = (stop_g >= g) && (stop_g < g + pe);
      for (int t = 0; t < pe; t++) begin
        r.tdc  = (t >= d) && (t < d + wi);
        r.trig = en && (t < TL);
        r.busy = 1'b1;
        r.done = 1'b0;
        r.evt  = CB'((t == pe - 1) ? ((cnt < 65535) ? cnt + 1 : cnt) : cnt);
        exp_q.push_back(r);
      end
      if (cnt < 65535) cnt++;
      g += pe;
      if (last_p || (rep != 0 && cnt == rep)) break;
    end
    r = '{tdc: 1'b0, trig: 1'b0, busy: 1'b0, done: 1'b1, evt: CB'(cnt)};
    exp_q.push_back(r);
    len = g;
  endtask

  // stop_e: edge index (START edge = 0) at which STOP is sampled; -1 = never
  task automatic run_burst(input int w, input int d, input int p, input int rep,
                           input bit en, input int stop_e);
    int len, waited, sg, last_e;
    @(posedge CLK); #1;
    WIDTH = WB'(w); DELAY = 8'(d); PERIOD = CB'(p); REPEAT = CB'(rep);
    EN_TRIG = en; START = 1'b1; STOP = (stop_e == 0);
`ifdef TDC_PULSE_GEN_RANDOM_EN
    WIDTH_MASK = 8'($urandom_range(0, 15));
`endif
    sg = (stop_e < 0) ? -1 : ((stop_e == 0) ? 0 : stop_e - 1);
    push_burst(w, d, p, rep, en, sg, len);
    @(posedge CLK); #1;
    // Config churn and a stray START while running must have no effect
    WIDTH = WB'($urandom_range(0, 4095)); DELAY = 8'($urandom_range(0, 255));
    PERIOD = CB'($urandom_range(0, 65535)); REPEAT = CB'($urandom_range(0, 65535));
    EN_TRIG = 1'($urandom_range(0, 1));
    last_e = (stop_e > 1) ? stop_e : 1;
    for (int e = 1; e <= last_e; e++) begin
      START = (e == 1);
      STOP  = (e == stop_e);
      @(posedge CLK); #1;
    end
    START = 1'b0; STOP = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < len + 50) begin
      @(posedge CLK);
      waited++;
    end
    chk("burst_complete_records_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
  endtask

  task automatic reset_mid();
    int n = 0, len;
    @(posedge CLK); #1;
    INVERT_TDC = 1'b1;
    WIDTH = WB'(20); DELAY = 8'd3; PERIOD = CB'(50); REPEAT = CB'(2);
    EN_TRIG = 1'b1; START = 1'b1;
    push_burst(20, 3, 50, 2, 1'b1, -1, len);
    @(posedge CLK); #1;
    START = 1'b0;
    while (TDC_OUT == INVERT_TDC && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("tdc_pulse_seen_before_reset", int'(TDC_OUT), 0);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_tdc_idle", int'(TDC_OUT), 1);
    chk("async_rst_trig_idle", int'(TRIG_OUT), int'(INVERT_TRIG));
    chk("async_rst_busy", int'(BUSY), 0);
    chk("async_rst_done", int'(DONE), 0);
    chk("async_rst_event_cnt", int'(EVENT_CNT), 0);
    exp_q.delete();
`ifdef TDC_PULSE_GEN_RANDOM_EN
    lfsr_m = 16'hACE1;
`endif
    @(negedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    INVERT_TDC = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_event_cnt", int'(EVENT_CNT), 0);
    chk("reset_tdc_idle", int'(TDC_OUT), 0);
    chk("reset_trig_idle", int'(TRIG_OUT), 0);
    INVERT_TDC = 1'b1; INVERT_TRIG = 1'b1;
    #1;
    chk("reset_tdc_idle_inv", int'(TDC_OUT), 1);
    chk("reset_trig_idle_inv", int'(TRIG_OUT), 1);
    INVERT_TDC = 1'b0; INVERT_TRIG = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    run_burst(10, 5, 40, 3, 1'b1, -1);      // basic burst, DONE at cycle 121
    run_burst(50, 20, 30, 2, 1'b1, -1);     // period stretched to 71
    run_burst(10, 5, 40, 0, 1'b1, 173);     // continuous, STOP at t=12 of period 5
    INVERT_TDC = 1'b1;
    run_burst(0, 7, 20, 3, 1'b0, -1);       // no TDC pulse, trigger gated, still counts
    INVERT_TDC = 1'b0;
    run_burst(5, 2, 10, 0, 1'b1, 0);        // START+STOP together: one period
    run_burst(8, 3, 20, 2, 1'b1, -1);       // loopback-style setting
    run_burst(3, 0, 0, 2, 1'b1, -1);        // PERIOD=0 falls back to minimum period
    reset_mid();
    run_burst(10, 5, 40, 1, 1'b1, -1);      // burst after mid-pulse reset

    for (int i = 0; i < 20; i++) begin
      int w, d, p, rep, se;
      bit en;
      w   = $urandom_range(0, 40);
      d   = $urandom_range(0, 40);
      p   = $urandom_range(0, 80);
      rep = $urandom_range(0, 4);
      en  = 1'($urandom_range(0, 1));
      se  = (rep == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 150) : -1;
      INVERT_TDC  = 1'($urandom_range(0, 1));
      INVERT_TRIG = 1'($urandom_range(0, 1));
      run_burst(w, d, p, rep, en, se);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
- Single-clock programmable pulse source that drives the TDC input path and the trigger input path of the 320 MHz TDC receiver.
- Per period it emits a trigger pulse, then a TDC pulse of programmed width at a programmed distance after the trigger. This gives known pulse widths and trigger distances for self-test and calibration.
- Sits in the test and firmware fabric. Its outputs are routed to TDC_IN and TRIG_IN, either in loopback or through I/O.

Parameters:
- CNT_BITS, 16, width of the period counter, PERIOD and REPEAT.
- WIDTH_BITS, 12, width of the WIDTH port; matches the 12-bit TDC value.
- TRIG_LEN, 4, trigger pulse length in CLK cycles; must be >=1 and <=255.

Ports:
- CLK  in  1  generator clock; all logic on rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- START  in  1  one-cycle request; latches configuration and starts a burst.
- STOP  in  1  one-cycle request; aborts the burst at the end of the current period.
- WIDTH  in  WIDTH_BITS  TDC pulse high time in cycles; 0 = no TDC pulse.
- DELAY  in  8  cycles from trigger rising edge to TDC rising edge.
- PERIOD  in  CNT_BITS  period length in cycles.
- REPEAT  in  CNT_BITS  number of periods; 0 = continuous until STOP.
- EN_TRIG  in  1  1 = emit the trigger pulse.
- INVERT_TDC  in  1  invert the TDC_OUT polarity (idle level becomes 1).
- INVERT_TRIG  in  1  invert the TRIG_OUT polarity.
- TDC_OUT  out  1  registered TDC pulse.
- TRIG_OUT  out  1  registered trigger pulse.
- BUSY  out  1  high while a burst runs.
- DONE  out  1  one-cycle strobe when a burst ends.
- EVENT_CNT  out  CNT_BITS  periods completed in the current or last burst.

Behaviour:
- Reset values: state=IDLE, BUSY=0, DONE=0, EVENT_CNT=0. TDC_OUT=INVERT_TDC and TRIG_OUT=INVERT_TRIG, so both outputs sit at their idle level. All counters are cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - START=1 latches WIDTH, DELAY, PERIOD, REPEAT and EN_TRIG into shadow registers, clears EVENT_CNT and t, then enters RUN.
  - Inputs are ignored outside this START cycle.
- RUN:
  - t counts 0..P_eff-1.
  - Outputs are registered, so t=0 appears on the pins 1 cycle after the START edge.
  - trig_raw is 1 for t<TRIG_LEN, gated by EN_TRIG.
  - tdc_raw is 1 for DELAY<=t<DELAY+WIDTH.
  - TDC_OUT = tdc_raw XOR INVERT_TDC; TRIG_OUT = trig_raw XOR INVERT_TRIG. The invert inputs are live, not latched.
- Effective period: P_eff = max(PERIOD, DELAY+WIDTH+1, TRIG_LEN+1). This guarantees at least one idle cycle per period on both outputs. The computation uses CNT_BITS+1 bits and saturates at 2^CNT_BITS-1.
- End of period: at t=P_eff-1, t wraps to 0 and EVENT_CNT increments, saturating at all ones.
- Leaving RUN: the burst goes to FINISH at that wrap if either condition holds:
  - the new EVENT_CNT equals REPEAT and REPEAT!=0;
  - a STOP request is pending.
- STOP handling: STOP in RUN sets a pending flag. The current period always completes, so no truncated pulses are ever produced.
- FINISH: DONE=1 for one cycle, BUSY=0, then IDLE. EVENT_CNT holds its value until the next START.
- BUSY is 1 in RUN and FINISH-entry: it rises with the first t=0 output cycle and falls in the DONE cycle.
- Simultaneous events:
  - START in RUN or FINISH is ignored.
  - START and STOP in the same IDLE cycle starts a burst that runs exactly 1 period.
- RST_N low mid-burst forces the reset values immediately; any partial pulse is truncated.
- Width rules:
  - DELAY+WIDTH is computed in WIDTH_BITS+1 bits; there is no wrap.
  - WIDTH=0 means TDC_OUT stays idle for the whole burst.
  - A TDC pulse shorter than 1 receiver DV_CLK cycle is legal; the receiver reports WIDTH*(320 MHz/CLK) bins.

Optional Feature:
- Macro: TDC_PULSE_GEN_RANDOM_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset).
  - The LFSR steps once per period.
  - The per-period TDC width is WIDTH + (lfsr[7:0] & WIDTH_MASK), where WIDTH_MASK is an additional 8-bit input port.
  - P_eff is recomputed per period using the randomized width.
- Undefined: the WIDTH_MASK port is absent and the width is constant.

Decomposition:
- Package tdc_pulse_gen_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - the LFSR seed and tap constants;
  - the default CNT_BITS and WIDTH_BITS.
- One natural sub-module, tdc_pulse_gen_lfsr: the LFSR with enable and async reset, instantiated only under the macro.
- Everything else lives in the top module.

Test Plan:
- Basic burst: WIDTH=10, DELAY=5, PERIOD=40, REPEAT=3, EN_TRIG=1, TRIG_LEN=4. Required response:
  - TRIG_OUT high for 4 cycles starting 1 cycle after START;
  - TDC_OUT high for 10 cycles starting 5 cycles after each trigger rise;
  - 3 periods of 40 cycles;
  - DONE at cycle 121, EVENT_CNT=3.
- Period extension: WIDTH=50, DELAY=20, PERIOD=30. Required response: measured period is 71 cycles, with exactly 1 low cycle between TDC pulses.
- Continuous run and STOP: REPEAT=0, STOP asserted at t=12 of period 5. Required response: period 5 completes fully, DONE follows, EVENT_CNT=5.
- Polarity and gating: INVERT_TDC=1, EN_TRIG=0, WIDTH=0. Required response: TDC_OUT stays at constant 1, TRIG_OUT stays at constant 0, and the burst still counts periods.
- Async reset mid-pulse: RST_N low during TDC_OUT high. Required response: outputs return to idle with no clock edge needed; BUSY=0 and EVENT_CNT=0; a new START works afterwards.
- Loopback with the receiver: CLK=160 MHz, WIDTH=8, DELAY=3. Required response: the receiver FIFO word holds TDC value 16 and trigger distance 6.
